dmem_responder: RTL and testbench



---
 rtl/dmem_responder.sv | 153 +++++++++++++++
 tb/tb_dmem_responder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready load/store port with WAIT_STATES latency.
// Optional alignment trap: define DMEM_MISALIGN_TRAP_EN.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_be;

    logic [31:0] mem [DEPTH_WORDS];

    logic        c_we;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic [3:0]  c_be;
    logic [31:0] off;
    logic [AW-1:0] idx;
    logic        in_range;
    logic        misal;
    logic        ok;
    logic        commit;
    logic [31:0] rd;

    // With zero wait states the commit edge is the acceptance edge,
    // so the live request is used instead of the latched copy.
    always_comb begin
        c_we    = lat_we;
        c_addr  = lat_addr;
        c_wdata = lat_wdata;
        c_be    = lat_be;
        if (state == IDLE) begin
            c_we    = req_we;
            c_addr  = req_addr;
            c_wdata = req_wdata;
            c_be    = req_be;
        end
    end

    // Address decode, range check and optional alignment check.
    always_comb begin
        off      = c_addr - BASE_ADDR;
        idx      = off[AW+1:2];
        in_range = (off >> 2) < DEPTH_WORDS;
`ifdef DMEM_MISALIGN_TRAP_EN
        misal = ((c_be == 4'hF) && (c_addr[1:0] != 2'b00)) ||
                (((c_be == 4'h3) || (c_be == 4'hC)) && c_addr[0]);
`else
        misal = 1'b0;
`endif
        ok     = in_range && !misal;
        rd     = (!c_we && ok) ? mem[idx] : 32'h0;
        commit = ((state == IDLE) && req_valid && (WAIT_STATES == 0)) ||
                 ((state == WAIT) && (cnt == 4'd1));
    end

    // Storage array write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (commit && c_we && ok) begin
            for (int i = 0; i < 4; i++) begin
                if (c_be[i]) begin
                    mem[idx][8*i +: 8] <= c_wdata[8*i +: 8];
                end
            end
        end
    end

    // Request/response FSM with registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= 32'h0;
            lat_wdata <= 32'h0;
            lat_be    <= 4'h0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        lat_we    <= req_we;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_be    <= req_be;
                        cnt       <= 4'(WAIT_STATES);
                        req_ready <= 1'b0;
                        if (WAIT_STATES == 0) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= rd;
                            rsp_err   <= !ok;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= rd;
                        rsp_err   <= !ok;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= 32'h0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: vector table plus scoreboard,
// with hand sequences for backpressure and reset during WAIT/RESP.
module tb_dmem_responder;

    localparam int unsigned WS = 3;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   split;

    dmem_responder #(
        .DEPTH_WORDS(64),
        .WAIT_STATES(WS),
        .BASE_ADDR(32'h0000_0000)
    ) u_dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .req_be(req_be),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic void add(input logic we, input logic [31:0] a,
                                input logic [31:0] d, input logic [3:0] be,
                                input logic [31:0] rd, input logic err);
        vec_t v;
        v.we = we; v.addr = a; v.wdata = d; v.be = be;
        v.rdata = rd; v.err = err;
        tbl.push_back(v);
    endfunction

    task automatic drive(input vec_t v);
        req_valid = 1'b1;
        req_we    = v.we;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_be    = v.be;
    endtask

    task automatic scramble();
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom);
    endtask

    task automatic xact(input vec_t v, input int hold, input string nm);
        vec_t e;
        int   lat;
        bit   got;
        exp_q.push_back(v);
        @(negedge clk);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL %s accept: got timeout expected req_ready", nm);
            void'(exp_q.pop_back());
            return;
        end
        drive(v);
        rsp_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        scramble();
        lat = 1;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            lat++;
            @(negedge clk);
        end
        e = exp_q.pop_front();
        if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL %s rsp: got timeout expected rsp_valid", nm);
            return;
        end
        check({nm, " latency"}, 32'(lat), 32'(WS + 1));
        check({nm, " rdata"}, rsp_rdata, e.rdata);
        check({nm, " err"}, 32'(rsp_err), 32'(e.err));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({nm, " hold valid"}, 32'(rsp_valid), 32'd1);
            check({nm, " hold rdata"}, rsp_rdata, e.rdata);
            check({nm, " hold ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check({nm, " done valid"}, 32'(rsp_valid), 32'd0);
        check({nm, " done ready"}, 32'(req_ready), 32'd1);
        check({nm, " done rdata"}, rsp_rdata, 32'h0);
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] a,
                                input logic [31:0] d, input logic [3:0] be,
                                input logic [31:0] rd, input logic err);
        vec_t v;
        v.we = we; v.addr = a; v.wdata = d; v.be = be;
        v.rdata = rd; v.err = err;
        return v;
    endfunction

    initial begin
        reset     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        req_be    = 4'h0;
        rsp_ready = 1'b1;

        add(1, 32'h00, 32'hA5A5A5A5, 4'hF, 32'h0, 0);
        add(1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0);
        add(0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 0);
        add(1, 32'h10, 32'h000000AA, 4'h1, 32'h0, 0);
        add(0, 32'h10, 32'h0, 4'hF, 32'hDEADBEAA, 0);
        add(1, 32'h10, 32'hFFFFFFFF, 4'h0, 32'h0, 0);
        add(0, 32'h10, 32'h0, 4'h1, 32'hDEADBEAA, 0);
        add(1, 32'h14, 32'hAABBCCDD, 4'hF, 32'h0, 0);
        add(1, 32'h16, 32'h55660000, 4'hC, 32'h0, 0);
        add(0, 32'h14, 32'h0, 4'hF, 32'h5566CCDD, 0);
        add(1, 32'h100, 32'hCAFEF00D, 4'hF, 32'h0, 1);
        add(0, 32'h00, 32'h0, 4'hF, 32'hA5A5A5A5, 0);
        add(0, 32'h100, 32'h0, 4'hF, 32'h0, 1);
        add(0, 32'hFFFFFFFC, 32'h0, 4'hF, 32'h0, 1);
        add(1, 32'hFC, 32'h01020304, 4'hF, 32'h0, 0);
        add(0, 32'hFC, 32'h0, 4'hF, 32'h01020304, 0);
        add(1, 32'h20, 32'h0BADF00D, 4'hF, 32'h0, 0);
        add(0, 32'h20, 32'h0, 4'h0, 32'h0BADF00D, 0);
        split = tbl.size();
        add(1, 32'h22, 32'h77777777, 4'hF, 32'h0, MIS);
        add(0, 32'h20, 32'h0, 4'hF,
            MIS ? 32'h0BADF00D : 32'h77777777, 0);
        add(1, 32'h30, 32'h12345678, 4'hF, 32'h0, 0);
        add(1, 32'h31, 32'h0000ABCD, 4'h3, 32'h0, MIS);
        add(0, 32'h30, 32'h0, 4'hF,
            MIS ? 32'h12345678 : 32'h1234ABCD, 0);

        #3 reset = 1'b1;
        #14 reset = 1'b0;
        @(posedge clk);
        #1;
        check("reset valid", 32'(rsp_valid), 32'd0);
        check("reset err", 32'(rsp_err), 32'd0);
        check("reset rdata", rsp_rdata, 32'h0);
        check("reset ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < split; i++) begin
            xact(tbl[i], 0, $sformatf("vec%0d", i));
        end

        xact(mk(0, 32'h10, 32'h0, 4'hF, 32'hDEADBEAA, 0), 5, "bp");

        @(negedge clk);
        drive(mk(1, 32'h20, 32'h12345678, 4'hF, 32'h0, 0));
        @(posedge clk);
        @(negedge clk);
        scramble();
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                seen = seen | rsp_valid;
            end
            check("rstwait no rsp", 32'(seen), 32'd0);
        end
        check("rstwait ready", 32'(req_ready), 32'd1);
        xact(mk(0, 32'h20, 32'h0, 4'hF, 32'h0BADF00D, 0), 0, "rstwait ld");

        @(negedge clk);
        drive(mk(1, 32'h40, 32'h55555555, 4'hF, 32'h0, 0));
        rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        scramble();
        begin
            bit got;
            got = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (rsp_valid) begin
                    got = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            check("rstresp valid", 32'(got), 32'd1);
        end
        reset = 1'b1;
        #2;
        check("rstresp cleared", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        rsp_ready = 1'b1;
        xact(mk(0, 32'h40, 32'h0, 4'hF, 32'h55555555, 0), 0, "rstresp ld");

        for (int i = split; i < tbl.size(); i++) begin
            xact(tbl[i], 0, $sformatf("vec%0d", i));
        end

        check("scoreboard empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
